// File: rtl/alu_sequencer.sv
// Command sequencer for an external combinational ALU: buffers commands in a small FIFO,
// issues them one at a time and returns each registered result through a valid/ready port.
module alu_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    input  logic                  cmd_use_acc,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_neg,
    output logic [2:0]            operation,
    output logic [DATA_WIDTH-1:0] alu_in1,
    output logic [DATA_WIDTH-1:0] alu_in2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    input  logic                  neg_flag,
    output logic                  busy,
    output logic [15:0]           op_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]            op;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  use_acc;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                state_q, state_d;
    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    entry_t                head;
    logic [AW:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d, res_q, res_d, in1_q, in1_d, in2_q, in2_d;
    logic                  neg_q, neg_d;
    logic [2:0]            op_q, op_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  empty, full, push, pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];
    assign push  = cmd_valid && !full;

    assign cmd_ready  = !full;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = res_q;
    assign rsp_neg    = neg_q;
    assign operation  = op_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign busy       = (state_q != IDLE) || !empty;
    assign op_count   = cnt_q;

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        acc_d   = acc_q;
        res_d   = res_q;
        neg_d   = neg_q;
        op_d    = op_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                res_d   = alu_out;
                neg_d   = neg_flag;
                acc_d   = alu_out;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // ALU ports only change on a pop, so they hold the last issued command while idle.
        if (pop) begin
            op_d   = head.op;
            in1_d  = head.use_acc ? acc_q : head.a;
            in2_d  = head.b;
            rptr_d = rptr_q + (AW+1)'(1);
        end

        if (push) begin
            mem_d[wptr_q[AW-1:0]] = '{op: cmd_op, a: cmd_a, b: cmd_b, use_acc: cmd_use_acc};
            wptr_d = wptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            neg_q   <= 1'b0;
            op_q    <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            neg_q   <= neg_d;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed scenarios plus a randomized run
// compared against an in-order queue model with its own accumulator.
module tb_alu_sequencer;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_use_acc;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_a, cmd_b;
    logic          rsp_valid, rsp_ready, rsp_neg;
    logic [DW-1:0] rsp_result;
    logic [2:0]    operation;
    logic [DW-1:0] alu_in1, alu_in2, alu_out;
    logic          neg_flag, busy;
    logic [15:0]   op_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        bit [2:0]    op;
        bit [DW-1:0] a;
        bit [DW-1:0] b;
        bit          ua;
    } cmd_t;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_neg(rsp_neg),
        .operation(operation), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_out(alu_out), .neg_flag(neg_flag),
        .busy(busy), .op_count(op_count)
    );

    // ALU stub: 000 add, 001 subtract, flag is the result sign bit.
    always_comb begin
        alu_out  = (operation == 3'b001) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
        neg_flag = alu_out[DW-1];
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    // Offers one command until accepted; returns just after the accepting edge.
    task automatic send(input bit [2:0] op, input bit [DW-1:0] a, input bit [DW-1:0] b,
                        input bit ua, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Waits for a response and accepts it; returns just after the handshake edge.
    task automatic take(output bit [DW-1:0] res, output bit neg, output bit ok);
        ok = 1'b0; res = '0; neg = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            res = rsp_result; neg = rsp_neg;
            rsp_ready = 1'b1;
            @(posedge clk);
            #1 rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_use_acc = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if ({rsp_valid, rsp_neg, busy} !== 3'b000) $display("FAIL reset_flags: got %b required 000", {rsp_valid, rsp_neg, busy}); else passed++;
        total++; if (rsp_result !== '0) $display("FAIL reset_result: got %h required 0", rsp_result); else passed++;
        total++; if ({operation, alu_in1, alu_in2} !== '0) $display("FAIL reset_alu_ports: got %h/%h/%h required 0", operation, alu_in1, alu_in2); else passed++;
        total++; if (op_count !== 16'd0) $display("FAIL reset_op_count: got %0d required 0", op_count); else passed++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_latency;
        bit ok, neg; bit [DW-1:0] res; bit [2:0] vseq;
        send(3'b000, 24'd10, 24'd10, 1'b0, ok);
        total++; if (!ok) $display("FAIL lat_accept: got no accept required accept"); else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vseq[i] = rsp_valid;
        end
        total++; if (vseq !== 3'b100) $display("FAIL lat_timing: rsp_valid over T+1..T+3 got %b required 100 (msb=T+3)", vseq); else passed++;
        take(res, neg, ok);
        total++; if (!ok || res !== 24'd20 || neg !== 1'b0) $display("FAIL lat_result: got %h neg %b required 000014 neg 0", res, neg); else passed++;
        @(negedge clk);
        total++; if (op_count !== 16'd1) $display("FAIL lat_op_count: got %0d required 1", op_count); else passed++;
        repeat (3) @(negedge clk);
        total++; if ({operation, alu_in1, alu_in2} !== {3'b000, 24'd10, 24'd10} || busy !== 1'b0)
            $display("FAIL idle_hold: got op %b in1 %0d in2 %0d busy %b required 000 10 10 0", operation, alu_in1, alu_in2, busy); else passed++;
    endtask

    task automatic test_sub;
        bit ok, neg; bit [DW-1:0] res;
        send(3'b001, 24'd20, 24'd84, 1'b0, ok);
        take(res, neg, ok);
        total++; if (!ok || res !== 24'hFFFFC0 || neg !== 1'b1) $display("FAIL sub_result: got %h neg %b required ffffc0 neg 1", res, neg); else passed++;
    endtask

    task automatic test_acc;
        bit ok, neg; bit [DW-1:0] res;
        send(3'b000, 24'd5, 24'd7, 1'b0, ok);
        send(3'b000, 24'd999, 24'd3, 1'b1, ok);
        take(res, neg, ok);
        total++; if (!ok || res !== 24'd12) $display("FAIL acc_first: got %0d required 12", res); else passed++;
        take(res, neg, ok);
        total++; if (!ok || res !== 24'd15) $display("FAIL acc_second: got %0d required 15", res); else passed++;
    endtask

    task automatic test_backpressure;
        int nacc = 0, nrsp = 0, rsp_before = -1;
        bit took6 = 1'b0;
        rsp_ready = 1'b0;
        cmd_op = 3'b000; cmd_b = 24'd1; cmd_use_acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            cmd_valid = 1'b1; cmd_a = 24'(100 + nacc);
            if (cmd_ready) nacc++;
        end
        total++; if (nacc != 5) $display("FAIL bp_accepted: got %0d required 5", nacc); else passed++;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) $display("FAIL bp_ready_low: got %b required 0", cmd_ready); else passed++;
        rsp_ready = 1'b1;
        for (int c = 0; c < 100 && nrsp < 6; c++) begin
            if (c > 0) @(negedge clk);
            if (took6) cmd_valid = 1'b0;
            if (rsp_valid) begin
                total++; if (rsp_result !== 24'(101 + nrsp)) $display("FAIL bp_order[%0d]: got %0d required %0d", nrsp, rsp_result, 101 + nrsp); else passed++;
                nrsp++;
            end
            if (cmd_valid && cmd_ready) begin
                took6 = 1'b1;
                rsp_before = nrsp;
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        total++; if (nrsp != 6) $display("FAIL bp_count: got %0d responses required 6", nrsp); else passed++;
        total++; if (!took6 || rsp_before < 1) $display("FAIL bp_sixth: accepted %b after %0d responses required accept after >=1", took6, rsp_before); else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok; int seen = 0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(3'b000, 24'(i), 24'd2, 1'b0, ok);
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
        total++; if (rsp_valid !== 1'b1) $display("FAIL rm_setup: rsp_valid got %b required 1", rsp_valid); else passed++;
        @(negedge clk);
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_a = 24'd77; cmd_b = 24'd1;
        @(negedge clk);
        total++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) $display("FAIL rm_flags: valid/busy/ready got %b required 001", {rsp_valid, busy, cmd_ready}); else passed++;
        total++; if (op_count !== 16'd0 || rsp_result !== '0) $display("FAIL rm_state: op_count %0d result %h required 0 0", op_count, rsp_result); else passed++;
        @(negedge clk);
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen++;
        end
        rsp_ready = 1'b0;
        total++; if (seen != 0) $display("FAIL rm_no_response: got %0d active cycles required 0", seen); else passed++;
    endtask

    task automatic test_random;
        cmd_t q[$];
        cmd_t c;
        bit [DW-1:0] macc = '0, in1, exp;
        bit [15:0] mcnt = '0;
        int ncyc = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            total++; if (busy !== (q.size() != 0)) $display("FAIL rnd_busy@%0d: got %b required %b", cyc, busy, q.size() != 0); else passed++;
            total++; if (op_count !== mcnt) $display("FAIL rnd_op_count@%0d: got %0d required %0d", cyc, op_count, mcnt); else passed++;
            if (cyc >= 600 && q.size() == 0) break;
            rsp_ready   = ($urandom_range(0, 3) != 0) || cyc >= 600;
            cmd_valid   = ($urandom_range(0, 2) != 0) && cyc < 600;
            cmd_op      = 3'($urandom_range(0, 1));
            cmd_a       = DW'($urandom);
            cmd_b       = DW'($urandom);
            cmd_use_acc = 1'($urandom_range(0, 1));
            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    total++; $display("FAIL rnd_extra_rsp@%0d: got response %h required none", cyc, rsp_result);
                end else begin
                    c   = q.pop_front();
                    in1 = c.ua ? macc : c.a;
                    exp = (c.op == 3'b001) ? in1 - c.b : in1 + c.b;
                    macc = exp;
                    mcnt++;
                    total++; if (rsp_result !== exp || rsp_neg !== exp[DW-1])
                        $display("FAIL rnd_result@%0d: got %h neg %b required %h neg %b", cyc, rsp_result, rsp_neg, exp, exp[DW-1]); else passed++;
                end
            end
            if (cmd_valid && cmd_ready) q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b, ua: cmd_use_acc});
            ncyc = cyc;
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        total++; if (q.size() != 0) $display("FAIL rnd_drain: %0d commands outstanding after %0d cycles required 0", q.size(), ncyc); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sub();
        test_acc();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
